// File: rtl/adc_control_if.sv
// Bus between the ADC capture front end, the accumulator and the host register bank.
// The master side drives samples, strobes and the publish period; the slave side returns results.
interface adc_control_if;
    logic [31:0]  update_time;
    logic [255:0] adcdata;
    logic [15:0]  adcready;

    logic [31:0]  adc0data;
    logic [31:0]  adc1data;
    logic [31:0]  adc2data;
    logic [31:0]  adc3data;
    logic [31:0]  adc4data;
    logic [31:0]  adc5data;
    logic [31:0]  adc6data;
    logic [31:0]  adc7data;
    logic [31:0]  adc8data;
    logic [31:0]  adc9data;
    logic [31:0]  adcadata;
    logic [31:0]  adcbdata;
    logic [31:0]  adccdata;
    logic [31:0]  adcddata;
    logic [31:0]  adcedata;
    logic [31:0]  adcfdata;

    modport master (
        output update_time, adcdata, adcready,
        input  adc0data, adc1data, adc2data, adc3data,
        input  adc4data, adc5data, adc6data, adc7data,
        input  adc8data, adc9data, adcadata, adcbdata,
        input  adccdata, adcddata, adcedata, adcfdata
    );

    modport slave (
        input  update_time, adcdata, adcready,
        output adc0data, adc1data, adc2data, adc3data,
        output adc4data, adc5data, adc6data, adc7data,
        output adc8data, adc9data, adcadata, adcbdata,
        output adccdata, adcddata, adcedata, adcfdata
    );
endinterface

// File: rtl/adc_control.sv
// Sixteen-channel sample accumulator: sums signed samples on strobe rising edges and
// publishes {count, sum} per channel every update_time+1 cycles, then restarts the window.
module adc_control (
    input  logic          clk,
    input  logic          rst,
    adc_control_if.slave  bus
);

    localparam int NUM_CH = 16;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    logic [15:0] ready_q;
    logic [15:0] ready_d;
    logic [31:0] tcnt_q;
    logic [31:0] tcnt_d;
    logic [23:0] acc_sum_q [NUM_CH];
    logic [23:0] acc_sum_d [NUM_CH];
    logic [7:0]  acc_cnt_q [NUM_CH];
    logic [7:0]  acc_cnt_d [NUM_CH];
    logic [31:0] result_q  [NUM_CH];
    logic [31:0] result_d  [NUM_CH];

    logic        publish;
    logic [15:0] sample_event;
    logic [15:0] sample    [NUM_CH];
    logic [23:0] sum_upd   [NUM_CH];
    logic [7:0]  cnt_upd   [NUM_CH];

    // Period counter; >= lets a shrunk period take effect immediately.
    always_comb begin
        ready_d      = bus.adcready;
        sample_event = bus.adcready & ~ready_q;
        publish      = (tcnt_q >= bus.update_time);
        tcnt_d       = publish ? 32'd0 : tcnt_q + 32'd1;
    end

    // The count cap at 255 keeps the 24-bit sum from ever overflowing.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sample[i]  = bus.adcdata[16*i +: 16];
            sum_upd[i] = acc_sum_q[i];
            cnt_upd[i] = acc_cnt_q[i];
            if (sample_event[i] && (acc_cnt_q[i] != CNT_MAX)) begin
                sum_upd[i] = acc_sum_q[i] + {{8{sample[i][15]}}, sample[i]};
                cnt_upd[i] = acc_cnt_q[i] + 8'd1;
            end
        end
    end

    // A publish captures the window including this cycle's samples and starts a fresh window.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            result_d[i]  = result_q[i];
            acc_sum_d[i] = sum_upd[i];
            acc_cnt_d[i] = cnt_upd[i];
            if (publish) begin
                result_d[i]  = {cnt_upd[i], sum_upd[i]};
                acc_sum_d[i] = 24'd0;
                acc_cnt_d[i] = 8'd0;
            end
        end
    end

    // ready_q tracks the strobes even in reset so a strobe held across release is not an event.
    always_ff @(posedge clk) begin
        ready_q <= ready_d;
        if (rst) begin
            tcnt_q <= 32'd0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_sum_q[i] <= 24'd0;
                acc_cnt_q[i] <= 8'd0;
                result_q[i]  <= 32'd0;
            end
        end else begin
            tcnt_q <= tcnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_sum_q[i] <= acc_sum_d[i];
                acc_cnt_q[i] <= acc_cnt_d[i];
                result_q[i]  <= result_d[i];
            end
        end
    end

    assign bus.adc0data = result_q[0];
    assign bus.adc1data = result_q[1];
    assign bus.adc2data = result_q[2];
    assign bus.adc3data = result_q[3];
    assign bus.adc4data = result_q[4];
    assign bus.adc5data = result_q[5];
    assign bus.adc6data = result_q[6];
    assign bus.adc7data = result_q[7];
    assign bus.adc8data = result_q[8];
    assign bus.adc9data = result_q[9];
    assign bus.adcadata = result_q[10];
    assign bus.adcbdata = result_q[11];
    assign bus.adccdata = result_q[12];
    assign bus.adcddata = result_q[13];
    assign bus.adcedata = result_q[14];
    assign bus.adcfdata = result_q[15];

endmodule

// File: tb/tb_adc_control.sv
// Scoreboard bench for adc_control: stimulus queues expected outputs stamped with the clock
// edge they must appear after; a negedge monitor compares them against the DUT.
module tb_adc_control;

    logic clk;
    logic rst;

    adc_control_if bus ();

    adc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    typedef struct {
        int unsigned at_edge;
        int          ch;
        logic [31:0] value;
        string       name;
    } exp_item_t;

    exp_item_t   sb_q[$];
    int unsigned edge_count = 0;
    int unsigned base_edge  = 0;
    int          compared   = 0;
    int          mismatched = 0;

    logic [15:0] all_samples [16];
    logic [31:0] all_expected [16];
    logic [255:0] all_data;

    always @(posedge clk) edge_count <= edge_count + 1;

    function automatic logic [31:0] get_out(input int ch);
        case (ch)
            0:  return bus.adc0data;
            1:  return bus.adc1data;
            2:  return bus.adc2data;
            3:  return bus.adc3data;
            4:  return bus.adc4data;
            5:  return bus.adc5data;
            6:  return bus.adc6data;
            7:  return bus.adc7data;
            8:  return bus.adc8data;
            9:  return bus.adc9data;
            10: return bus.adcadata;
            11: return bus.adcbdata;
            12: return bus.adccdata;
            13: return bus.adcddata;
            14: return bus.adcedata;
            default: return bus.adcfdata;
        endcase
    endfunction

    function automatic logic [255:0] one_ch(input int ch, input logic [15:0] v);
        logic [255:0] d;
        d = '0;
        d[16*ch +: 16] = v;
        return d;
    endfunction

    task automatic expect_at(input int unsigned e, input int ch, input logic [31:0] v, input string name);
        exp_item_t it;
        it.at_edge = e;
        it.ch      = ch;
        it.value   = v;
        it.name    = name;
        sb_q.push_back(it);
    endtask

    task automatic checkOutput(input exp_item_t it);
        logic [31:0] act;
        act = get_out(it.ch);
        compared++;
        if (act !== it.value) begin
            mismatched++;
            $display("[TB] FAIL %s ch%0d edge %0d: got %h, expected %h", it.name, it.ch, it.at_edge, act, it.value);
        end
    endtask

    // Monitor: every stamped expectation is compared just after its edge.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at_edge == edge_count) begin
                checkOutput(sb_q[i]);
                sb_q.delete(i);
            end else if (sb_q[i].at_edge < edge_count) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL %s ch%0d: edge %0d was never checked", sb_q[i].name, sb_q[i].ch, sb_q[i].at_edge);
                sb_q.delete(i);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] rdy, input logic [255:0] data);
        bus.adcready = rdy;
        bus.adcdata  = data;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input logic [15:0] rdy);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 16; c++) expect_at(edge_count + 1, c, 32'h0, "reset_zero");
            applyStimulus(rdy, '0);
        end
        rst = 1'b0;
        base_edge = edge_count + 1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0]  rdy;
        logic [255:0] data;
        int unsigned  b;

        all_samples = '{16'hFFF0, 16'h00F0, 16'h0100, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h1234,
                        16'hEDCC, 16'h0000, 16'h4000, 16'hC000, 16'h00FF, 16'hFF01, 16'hFE00, 16'h28EE};
        all_expected = '{32'h01FFFFF0, 32'h010000F0, 32'h01000100, 32'h01FF8000,
                         32'h01007FFF, 32'h01000001, 32'h01FFFFFF, 32'h01001234,
                         32'h01FFEDCC, 32'h01000000, 32'h01004000, 32'h01FFC000,
                         32'h010000FF, 32'h01FFFF01, 32'h01FFFE00, 32'h010028EE};
        all_data = '0;
        for (int c = 0; c < 16; c++) all_data[16*c +: 16] = all_samples[c];

        rst             = 1'b1;
        bus.adcready    = 16'hFFFF;
        bus.adcdata     = '0;
        bus.update_time = 32'd9;
        @(negedge clk);

        // Reset with all strobes high: no events until a strobe falls and rises again.
        do_reset(3, 16'hFFFF);
        b = base_edge;
        for (int c = 0; c < 16; c++) expect_at(b + 9, c, 32'h0, "held_strobe_no_event");
        expect_at(b + 19, 2, 32'h01000005, "rearmed_strobe");
        expect_at(b + 19, 0, 32'h0, "rearm_other_ch");
        expect_at(b + 21, 2, 32'h01000005, "output_hold");
        for (int k = 0; k < 24; k++) begin
            rdy  = 16'hFFFF;
            data = one_ch(2, 16'h0005);
            if (k == 12) rdy = 16'hFFFB;
            if (k >= 20) begin
                rdy  = (k == 21) ? 16'h0002 : 16'h0000;
                data = one_ch(1, 16'h0007);
            end
            applyStimulus(rdy, data);
        end

        // Mid-window reset, then basic accumulate, all channels, and publish-edge events.
        do_reset(2, 16'h0000);
        b = base_edge;
        expect_at(b + 8, 0, 32'h0, "hold_before_publish");
        expect_at(b + 9, 0, 32'h03FFFFD0, "basic_acc");
        expect_at(b + 9, 1, 32'h0, "reset_discard");
        expect_at(b + 9, 15, 32'h0, "no_strobe_zero");
        for (int c = 0; c < 16; c++) expect_at(b + 19, c, all_expected[c], "all_ch_w1");
        for (int c = 0; c < 16; c++) expect_at(b + 29, c, all_expected[c], "all_ch_w2");
        expect_at(b + 39, 5, 32'h02000013, "event_on_publish");
        expect_at(b + 49, 5, 32'h01000020, "next_window_fresh");
        for (int k = 0; k < 50; k++) begin
            rdy  = 16'h0000;
            data = '0;
            if (k == 1 || k == 3 || k == 5) begin
                rdy  = 16'h0001;
                data = one_ch(0, 16'hFFF0);
            end
            if (k == 12 || k == 22) begin
                rdy  = 16'hFFFF;
                data = all_data;
            end
            if (k == 35) begin rdy = 16'h0020; data = one_ch(5, 16'h0003); end
            if (k == 39) begin rdy = 16'h0020; data = one_ch(5, 16'h0010); end
            if (k == 41) begin rdy = 16'h0020; data = one_ch(5, 16'h0020); end
            applyStimulus(rdy, data);
        end

        // Publish every cycle.
        bus.update_time = 32'd0;
        do_reset(1, 16'h0000);
        b = base_edge;
        expect_at(b + 0, 7, 32'h0, "ut0_idle");
        expect_at(b + 1, 7, 32'h01000ABC, "ut0_event");
        expect_at(b + 2, 7, 32'h0, "ut0_held_high");
        expect_at(b + 3, 7, 32'h0, "ut0_low");
        expect_at(b + 4, 7, 32'h01FFF000, "ut0_event_neg");
        expect_at(b + 5, 7, 32'h0, "ut0_after");
        for (int k = 0; k < 6; k++) begin
            rdy  = (k == 1 || k == 2 || k == 4) ? 16'h0080 : 16'h0000;
            data = one_ch(7, (k == 4) ? 16'hF000 : ((k == 1) ? 16'h0ABC : 16'h1111));
            applyStimulus(rdy, data);
        end

        // Count cap: 300 events, only 255 kept.
        bus.update_time = 32'd2000;
        do_reset(1, 16'h0000);
        b = base_edge;
        expect_at(b + 1999, 3, 32'h0, "cap_before_publish");
        expect_at(b + 2000, 3, 32'hFF7F7F01, "count_cap");
        expect_at(b + 2000, 4, 32'h0, "cap_other_ch");
        for (int k = 0; k <= 2000; k++) begin
            rdy = (k < 600 && (k % 2) == 1) ? 16'h0008 : 16'h0000;
            applyStimulus(rdy, one_ch(3, 16'h7FFF));
        end

        // Period shrink from 100 to 5 while tcnt is 50.
        bus.update_time = 32'd100;
        do_reset(1, 16'h0000);
        b = base_edge;
        expect_at(b + 49, 9, 32'h0, "period_before_shrink");
        expect_at(b + 50, 9, 32'h01000002, "period_shrink_publish");
        expect_at(b + 55, 9, 32'h01000002, "period_hold");
        expect_at(b + 56, 9, 32'h01000004, "period_new_6");
        expect_at(b + 61, 9, 32'h01000004, "period_hold2");
        expect_at(b + 62, 9, 32'h0, "period_new_6_empty");
        for (int k = 0; k < 63; k++) begin
            if (k == 50) bus.update_time = 32'd5;
            rdy  = 16'h0000;
            data = '0;
            if (k == 10) begin rdy = 16'h0200; data = one_ch(9, 16'h0002); end
            if (k == 53) begin rdy = 16'h0200; data = one_ch(9, 16'h0004); end
            applyStimulus(rdy, data);
        end

        applyStimulus(16'h0000, '0);
        applyStimulus(16'h0000, '0);

        while (sb_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s ch%0d: expectation for edge %0d left unchecked", sb_q[0].name, sb_q[0].ch, sb_q[0].at_edge);
            void'(sb_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
